// File: rtl/pdm_pkg.sv
// Shared definitions for the PDM microphone capture path.
package pdm_pkg;

  // Sequencer states; the encoding is visible to software via the state port.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } pdm_state_e;

  // Default PCM sample width produced by the CIC3 decimator.
  localparam int unsigned PDM_DATA_W = 16;

endpackage

// File: rtl/pdm_sample_fifo.sv
// Single-clock sample FIFO with flush; accepts a push while full when a pop
// happens in the same cycle. Occupancy is tracked by a separate counter.
module pdm_sample_fifo
  import pdm_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DATA_W = PDM_DATA_W,
  parameter int unsigned LVL_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] push_data,
  output logic [DATA_W-1:0] head,
  output logic [LVL_W-1:0]  level,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  count;
  logic              do_push;
  logic              do_pop;

  assign empty = (count == '0);
  assign full  = (count == LVL_W'(DEPTH));

  // A pop on empty is ignored; a push on full only lands if a pop frees a slot.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sample storage, intentionally not reset.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head  = empty ? '0 : mem[rd_ptr];
  assign level = count;

endmodule

// File: rtl/pdm_capture_ctrl.sv
// Capture sequencer: gates the PDM clock, discards settling samples after
// start, buffers PCM samples and raises level/overrun interrupts.
module pdm_capture_ctrl
  import pdm_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DATA_W = PDM_DATA_W,
  parameter int unsigned LVL_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [7:0]        settle_count,
  input  logic [LVL_W-1:0]  watermark,
  input  logic              pcm_valid,
  input  logic [DATA_W-1:0] pcm_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic [LVL_W-1:0]  level,
  output logic              clk_en,
  output logic [1:0]        state,
  output logic              overrun,
  input  logic              overrun_clr,
  output logic              irq
);

  pdm_state_e state_q;
  pdm_state_e state_d;
  logic [7:0] settle_q;
  logic [7:0] settle_d;
  logic       clk_en_q;
  logic       overrun_q;
  logic       fifo_push;
  logic       fifo_flush;
  logic       fifo_full;
  logic       fifo_empty;
  logic       overrun_set;

  pdm_sample_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .LVL_W  (LVL_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .pop       (rd_en),
    .flush     (fifo_flush),
    .push_data (pcm_data),
    .head      (rd_data),
    .level     (level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // State, settle counter and clock-enable registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      settle_q <= '0;
      clk_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      clk_en_q <= (state_d != ST_IDLE);
    end
  end

  // Next-state logic; stop always takes priority over start and pcm_valid.
  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          fifo_flush = 1'b1;
          settle_d   = settle_count;
          state_d    = (settle_count == '0) ? ST_RUN : ST_WARMUP;
        end
      end
      ST_WARMUP: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (pcm_valid) begin
          settle_d = settle_q - 8'd1;
          if (settle_q == 8'd1) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (pcm_valid) begin
          fifo_push = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A push while full is dropped unless a pop in the same cycle makes room.
  assign overrun_set = fifo_push && fifo_full && !rd_en;

  // Sticky overrun flag; a new overrun beats a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
    end else if (overrun_set) begin
      overrun_q <= 1'b1;
    end else if (fifo_flush || overrun_clr) begin
      overrun_q <= 1'b0;
    end
  end

  assign state   = state_q;
  assign clk_en  = clk_en_q;
  assign overrun = overrun_q;
  assign irq     = ((watermark != '0) && (level >= watermark)) || overrun_q;

endmodule
